afifo_rd_burst_engine: RTL

//  Synthesizable read-side engine for the async FIFO, in the rclk domain; successor to the per-word read driver.

---
 rtl/afifo_rd_pkg.sv | 25 ++
 rtl/afifo_rd_out_slot.sv | 48 ++++
 rtl/afifo_rd_burst_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_pkg.sv
// Shared types for the async-FIFO read-side burst engine.
//   rd_mode_t   : command mode (normal burst / deliberate underflow injection)
//   rd_status_t : per-command completion code
//   rd_state_t  : engine FSM states
package afifo_rd_pkg;

  typedef enum logic {
    RD_NORMAL        = 1'b0,
    RD_UNDERFLOW_INJ = 1'b1
  } rd_mode_t;

  typedef enum logic [1:0] {
    RD_OK        = 2'd0,
    RD_TIMEOUT   = 2'd1,
    RD_UNDERFLOW = 2'd2
  } rd_status_t;

  typedef enum logic [1:0] {
    RD_ST_IDLE      = 2'd0,
    RD_ST_BURST     = 2'd1,
    RD_ST_UNDERFLOW = 2'd2,
    RD_ST_STATUS    = 2'd3
  } rd_state_t;

endpackage

// File: rtl/afifo_rd_out_slot.sv
// One-entry valid/ready output register for the read burst engine.
// Ports:
//   clk_i, rst_ni  : clock, async active-low reset
//   push_i         : load data_i/last_i into the slot (only legal when can_push_o)
//   data_i, last_i : word and end-of-command flag to load
//   ready_i        : downstream accepts the held word
//   can_push_o     : slot is empty or being drained this cycle
//   valid_o, data_o, last_o : slot contents; held stable while valid_o & !ready_i
module afifo_rd_out_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  can_push_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  assign can_push_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/afifo_rd_burst_engine.sv
// Read-side burst engine for the async FIFO (rclk domain).
// Takes burst commands (length + mode), pops words with a per-word empty
// retry budget, streams them out over valid/ready and reports one status
// record per command. Underflow injection pops exactly one word ignoring rempty.
// Ports:
//   rclk, rrst_n                 : clock, async active-low reset
//   cmd_valid/cmd_ready          : command handshake (ready only when idle)
//   cmd_len, cmd_mode            : words to read, RD_NORMAL / RD_UNDERFLOW_INJ
//   rempty, rdata, rinc          : FIFO read interface (rinc combinational)
//   out_valid/out_ready          : output stream handshake
//   out_data, out_last           : popped word, final word of command
//   status_valid                 : one-cycle status pulse
//   status_code/words/retries    : completion code, words popped, empty-wait total
// Optional build macro AFIFO_RD_STATS_EN adds stat_words, stat_timeouts,
// stat_underflows: free-running wrap-around counters cleared only by reset.
module afifo_rd_burst_engine
  import afifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LEN_W           = 8,
  parameter int unsigned MAX_EMPTY_RETRY = 16,
  parameter int unsigned RETRY_W         = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  rd_mode_t              cmd_mode,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  status_valid,
  output rd_status_t            status_code,
  output logic [LEN_W-1:0]      status_words,
  output logic [RETRY_W-1:0]    status_retries
`ifdef AFIFO_RD_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_timeouts,
  output logic [15:0]           stat_underflows
`endif
);

  localparam int unsigned RC_W = $clog2(MAX_EMPTY_RETRY + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_EMPTY_RETRY);

  rd_state_t          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [RC_W-1:0]    retry_cnt_q, retry_cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  rd_status_t         code_q, code_d;

  logic can_push;
  logic push_last;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= RD_ST_IDLE;
      len_q       <= '0;
      words_q     <= '0;
      retry_cnt_q <= '0;
      retries_q   <= '0;
      code_q      <= RD_OK;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      words_q     <= words_d;
      retry_cnt_q <= retry_cnt_d;
      retries_q   <= retries_d;
      code_q      <= code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    words_d      = words_q;
    retry_cnt_d  = retry_cnt_q;
    retries_d    = retries_q;
    code_d       = code_q;
    rinc         = 1'b0;
    push_last    = 1'b0;
    cmd_ready    = 1'b0;
    status_valid = 1'b0;

    case (state_q)
      RD_ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          len_d       = cmd_len;
          words_d     = '0;
          retry_cnt_d = '0;
          retries_d   = '0;
          code_d      = RD_OK;
          if (cmd_mode == RD_UNDERFLOW_INJ) begin
            state_d = RD_ST_UNDERFLOW;
          end else if (cmd_len == '0) begin
            state_d = RD_ST_STATUS;
          end else begin
            state_d = RD_ST_BURST;
          end
        end
      end

      RD_ST_BURST: begin
        if (!rempty && can_push) begin
          rinc        = 1'b1;
          words_d     = words_q + LEN_W'(1);
          retry_cnt_d = '0;
          push_last   = (words_q + LEN_W'(1)) == len_q;
          if (push_last) begin
            state_d = RD_ST_STATUS;
          end
        end else if (rempty) begin
          // The budget is checked before counting, so a full budget of
          // empty waits is recorded and the next empty cycle times out.
          if (retry_cnt_q == RC_MAX) begin
            state_d = RD_ST_STATUS;
            code_d  = RD_TIMEOUT;
          end else if (can_push) begin
            retry_cnt_d = retry_cnt_q + RC_W'(1);
            if (retries_q != '1) begin
              retries_d = retries_q + RETRY_W'(1);
            end
          end
        end
      end

      RD_ST_UNDERFLOW: begin
        if (can_push) begin
          rinc      = 1'b1;
          push_last = 1'b1;
          words_d   = LEN_W'(1);
          code_d    = RD_UNDERFLOW;
          state_d   = RD_ST_STATUS;
        end
      end

      RD_ST_STATUS: begin
        status_valid = 1'b1;
        state_d      = RD_ST_IDLE;
      end

      default: state_d = RD_ST_IDLE;
    endcase
  end

  afifo_rd_out_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slot (
    .clk_i      (rclk),
    .rst_ni     (rrst_n),
    .push_i     (rinc),
    .data_i     (rdata),
    .last_i     (push_last),
    .ready_i    (out_ready),
    .can_push_o (can_push),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .last_o     (out_last)
  );

  assign status_code    = code_q;
  assign status_words   = words_q;
  assign status_retries = retries_q;

`ifdef AFIFO_RD_STATS_EN
  logic [31:0] stat_words_q;
  logic [15:0] stat_timeouts_q;
  logic [15:0] stat_underflows_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      stat_words_q      <= '0;
      stat_timeouts_q   <= '0;
      stat_underflows_q <= '0;
    end else begin
      if (rinc) begin
        stat_words_q <= stat_words_q + 32'd1;
      end
      if (state_q == RD_ST_STATUS && code_q == RD_TIMEOUT) begin
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
      end
      if (state_q == RD_ST_STATUS && code_q == RD_UNDERFLOW) begin
        stat_underflows_q <= stat_underflows_q + 16'd1;
      end
    end
  end

  assign stat_words      = stat_words_q;
  assign stat_timeouts   = stat_timeouts_q;
  assign stat_underflows = stat_underflows_q;
`endif

endmodule
